// File: rtl/ibex_pkg.sv
// Shared types and constants for the bfloat16 add/sub arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ibex_pkg;

  // ALU operation codes; only ADD and SUB are served by the arbitrated adder.
  typedef enum logic [2:0] {
    FP_ALU_ADD = 3'd0,
    FP_ALU_SUB = 3'd1,
    FP_ALU_MUL = 3'd2,
    FP_ALU_DIV = 3'd3,
    FP_ALU_MIN = 3'd4,
    FP_ALU_MAX = 3'd5
  } fp_alu_op_e;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fp_arb_state_e;

  // Canonical quiet NaN returned for invalid operations and NaN inputs.
  localparam logic [15:0] FP_BF16_QNAN = 16'h7FC0;

  // Exponent field value marking Inf/NaN.
  localparam logic [7:0] FP_BF16_EXP_MAX = 8'hFF;

  // True for the operations the adder can execute.
  function automatic logic fp_op_supported(input fp_alu_op_e op);
    return (op == FP_ALU_ADD) || (op == FP_ALU_SUB);
  endfunction

endpackage

// File: rtl/fp_addsub_arb_add_sub.sv
// Combinational bfloat16 adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module Add_Sub
  import ibex_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] result_o
);

  // Unpacked operand fields; b's sign already reflects subtraction.
  logic        sa;
  logic        sb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [6:0]  fa;
  logic [6:0]  fb;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic [14:0] mag_a;
  logic [14:0] mag_b;

  // Datapath after magnitude ordering: big operand >= small operand.
  logic        swap;
  logic        s_big;
  logic        s_sml;
  logic [7:0]  e_big;
  logic [7:0]  e_sml;
  logic [10:0] m_big;
  logic [10:0] m_sml;
  logic [7:0]  diff;
  logic [3:0]  shamt;
  logic [21:0] align;
  logic [10:0] m_aln;
  logic        eff_sub;
  logic [11:0] sum;
  logic [3:0]  lz;
  logic        lz_found;
  logic [10:0] norm;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_rnd;
  logic        rnd_up;
  logic [7:0]  rnd_frac;

  assign sa = a_i[15];
  assign sb = b_i[15] ^ sub_i;
  assign ea = a_i[14:7];
  assign eb = b_i[14:7];
  assign fa = a_i[6:0];
  assign fb = b_i[6:0];

  // Classify operands; exponent-zero encodings are treated as zero.
  always_comb begin
    a_nan = (ea == FP_BF16_EXP_MAX) && (fa != 7'd0);
    b_nan = (eb == FP_BF16_EXP_MAX) && (fb != 7'd0);
    a_inf = (ea == FP_BF16_EXP_MAX) && (fa == 7'd0);
    b_inf = (eb == FP_BF16_EXP_MAX) && (fb == 7'd0);
    mag_a = (ea == 8'd0) ? 15'd0 : a_i[14:0];
    mag_b = (eb == 8'd0) ? 15'd0 : b_i[14:0];
  end

  // Order by magnitude and align the smaller significand with a sticky bit.
  always_comb begin
    swap = (mag_b > mag_a);
    if (swap) begin
      s_big = sb;
      s_sml = sa;
      e_big = eb;
      e_sml = ea;
      m_big = (eb == 8'd0) ? 11'd0 : {1'b1, fb, 3'b000};
      m_sml = (ea == 8'd0) ? 11'd0 : {1'b1, fa, 3'b000};
    end else begin
      s_big = sa;
      s_sml = sb;
      e_big = ea;
      e_sml = eb;
      m_big = (ea == 8'd0) ? 11'd0 : {1'b1, fa, 3'b000};
      m_sml = (eb == 8'd0) ? 11'd0 : {1'b1, fb, 3'b000};
    end
    diff    = e_big - e_sml;
    // Any shift of 12 or more leaves only sticky information.
    shamt   = (diff > 8'd11) ? 4'd12 : diff[3:0];
    align   = {m_sml, 11'd0} >> shamt;
    m_aln   = align[21:11] | {10'd0, |align[10:0]};
    eff_sub = s_big ^ s_sml;
    sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_aln})
                      : ({1'b0, m_big} + {1'b0, m_aln});
  end

  // Leading-zero count over the non-carry part of the sum.
  always_comb begin
    lz       = 4'd0;
    lz_found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!lz_found && sum[i]) begin
        lz       = 4'(10 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Normalize to a leading one in bit 10, then round to nearest even.
  always_comb begin
    if (sum[11]) begin
      norm   = sum[11:1] | {10'd0, sum[0]};
      e_norm = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      norm   = sum[10:0] << lz;
      e_norm = $signed({2'b00, e_big}) - $signed({6'd0, lz});
    end
    // norm[2] is the guard bit, norm[1:0] round/sticky, norm[3] the result lsb.
    rnd_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd_frac = {1'b0, norm[9:3]} + {7'd0, rnd_up};
    // Fraction overflow from rounding bumps the exponent; the fraction wraps to zero.
    e_rnd    = e_norm + (rnd_frac[7] ? 10'sd1 : 10'sd0);
  end

  // Special-case priority: NaN, Inf arithmetic, exact zero, underflow, overflow, normal.
  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result_o = FP_BF16_QNAN;
    end else if (a_inf) begin
      result_o = {sa, FP_BF16_EXP_MAX, 7'd0};
    end else if (b_inf) begin
      result_o = {sb, FP_BF16_EXP_MAX, 7'd0};
    end else if (!norm[10]) begin
      // Exact zero: negative only when both addends are negative.
      result_o = {sa & sb, 15'd0};
    end else if (e_norm < 10'sd1) begin
      result_o = {s_big, 15'd0};
    end else if (e_rnd > 10'sd254) begin
      result_o = {s_big, FP_BF16_EXP_MAX, 7'd0};
    end else begin
      result_o = {s_big, e_rnd[7:0], rnd_frac[6:0]};
    end
  end

endmodule

// File: rtl/fp_addsub_arb.sv
// Round-robin arbiter sharing one bfloat16 add/sub unit among NREQ requesters.
// Latency: 2 cycles from accept edge to rsp_valid_o; one result per 2 cycles back-to-back.
// Backpressure: response held stable until rsp_ready_i; no request accepted while it is held.
module fp_addsub_arb
  import ibex_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  req_ready_o,
  input  fp_alu_op_e       req_op_i [NREQ],
  input  logic [15:0]      req_a_i  [NREQ],
  input  logic [15:0]      req_b_i  [NREQ],
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [IDW-1:0]   rsp_id_o,
  output logic [15:0]      rsp_result_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  fp_arb_state_e state_q;
  fp_arb_state_e state_d;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nxt;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  int             cand;
  logic           take;

  // Operand registers: the only source feeding the adder.
  fp_alu_op_e     op_q;
  logic [15:0]    a_q;
  logic [15:0]    b_q;
  logic [IDW-1:0] id_q;

  logic [15:0]    add_res;
  logic           op_ok;

  logic [15:0]    rsp_result_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_err_q;

  // Pick the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
    ptr_nxt = (int'(grant_idx) == NREQ - 1) ? '0 : IDW'(int'(grant_idx) + 1);
  end

  // Next state and accept strobe; grants only in IDLE or a completing RESP.
  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          take    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          take    = grant_vld;
          state_d = grant_vld ? EXEC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst_i) begin
      take    = 1'b0;
      state_d = IDLE;
    end
    if (take) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= ptr_nxt;
    end
  end

  // Capture the granted request on the accept edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= FP_ALU_ADD;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
      id_q <= '0;
    end else if (take) begin
      op_q <= req_op_i[grant_idx];
      a_q  <= req_a_i[grant_idx];
      b_q  <= req_b_i[grant_idx];
      id_q <= grant_idx;
    end
  end

  assign op_ok = fp_op_supported(op_q);

  Add_Sub u_add_sub (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (op_q == FP_ALU_SUB),
    .result_o (add_res)
  );

  // Register the response in EXEC; unsupported ops bypass the adder with a quiet NaN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_result_q <= 16'h0000;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_result_q <= op_ok ? add_res : FP_BF16_QNAN;
      rsp_id_q     <= id_q;
      rsp_err_q    <= !op_ok;
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_result_o = rsp_result_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fp_addsub_arb.sv
`timescale 1ns/1ps
// Bench for fp_addsub_arb: table of bf16 vectors plus round-robin, backpressure and reset sequences.
// Latency: checks the 2-cycle accept-to-response timing per table vector.
// Backpressure: holds rsp_ready low for several cycles in one sequence.
module tb_fp_addsub_arb;
  import ibex_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  fp_alu_op_e       req_op [NREQ];
  logic [15:0]      req_a  [NREQ];
  logic [15:0]      req_b  [NREQ];
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [15:0]      rsp_result;
  logic             rsp_err;
  logic             busy;

  always #5 clk = ~clk;

  fp_addsub_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy)
  );

  typedef struct {
    int          port;
    fp_alu_op_e  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    res;
    logic           err;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] exp_res [NREQ];
  logic        exp_err [NREQ];
  int n_vec = 0;
  int n_err = 0;
  int n_grant = 0;
  int n_hs = 0;
  int last_grant = -1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Scoreboard: push the requester's expected result on each accept, pop on each response handshake.
  always @(negedge clk) begin
    sb_t e;
    n_vec++;
    if ($countones(req_ready) > 1) begin
      n_err++;
      $display("FAIL ready_onehot: got %b, want at most one bit", req_ready);
    end
    if (rst) begin
      chk("ready_in_reset", 16'(req_ready), 16'h0000);
    end else begin
      for (int p = 0; p < NREQ; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          sb.push_back('{id: IDW'(p), res: exp_res[p], err: exp_err[p]});
          n_grant++;
          last_grant = p;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_hs++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got id %0d result %h, want no response", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 16'(rsp_id), 16'(e.id));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_err", 16'(rsp_err), 16'(e.err));
        end
      end
    end
  end

  // Wait (bounded) for the next grant after count g0; report the granted port.
  task automatic wait_grant(input int g0, input string name, output int who);
    int t;
    t = 0;
    who = -1;
    while (n_grant == g0 && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (n_grant == g0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no grant, want a grant within 30 cycles", name);
    end else begin
      who = last_grant;
    end
  endtask

  // Wait (bounded) until every expected response has been seen.
  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({name, "_drain"}, 16'(sb.size()), 16'h0000);
  endtask

  task automatic set_port(input int p, input fp_alu_op_e op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic err);
    req_op[p]  = op;
    req_a[p]   = a;
    req_b[p]   = b;
    exp_res[p] = res;
    exp_err[p] = err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want completion before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    int   who;
    int   g0;
    int   hs0;

    tbl.push_back('{0, FP_ALU_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0});
    tbl.push_back('{1, FP_ALU_SUB, 16'h4000, 16'h3F80, 16'h3F80, 1'b0});
    tbl.push_back('{0, FP_ALU_ADD, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0});
    tbl.push_back('{1, FP_ALU_MUL, 16'h3F80, 16'h4000, 16'h7FC0, 1'b1});
    tbl.push_back('{0, FP_ALU_SUB, 16'h3F80, 16'h3F80, 16'h0000, 1'b0});
    tbl.push_back('{1, FP_ALU_ADD, 16'hC000, 16'h3F80, 16'hBF80, 1'b0});
    tbl.push_back('{0, FP_ALU_SUB, 16'h3F80, 16'h4000, 16'hBF80, 1'b0});
    tbl.push_back('{1, FP_ALU_ADD, 16'h7F7F, 16'h7F7F, 16'h7F80, 1'b0});
    tbl.push_back('{0, FP_ALU_ADD, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0});
    tbl.push_back('{1, FP_ALU_ADD, 16'h3F81, 16'h3B80, 16'h3F82, 1'b0});
    tbl.push_back('{0, FP_ALU_ADD, 16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0});
    tbl.push_back('{1, FP_ALU_SUB, 16'h4040, 16'h4000, 16'h3F80, 1'b0});
    tbl.push_back('{0, FP_ALU_ADD, 16'h3FC0, 16'h3FC0, 16'h4040, 1'b0});
    tbl.push_back('{1, FP_ALU_SUB, 16'h3F80, 16'h7F80, 16'hFF80, 1'b0});
    tbl.push_back('{0, FP_ALU_ADD, 16'h3F80, 16'h0000, 16'h3F80, 1'b0});
    tbl.push_back('{1, FP_ALU_DIV, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b1});

    // Reset with both requesters already valid.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set_port(0, FP_ALU_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    set_port(1, FP_ALU_ADD, 16'h4040, 16'h3F80, 16'h4080, 1'b0);
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_result", rsp_result, 16'h0000);
    chk("rst_id", 16'(rsp_id), 16'h0000);
    chk("rst_err", 16'(rsp_err), 16'h0000);
    chk("rst_ready", 16'(req_ready), 16'h0000);

    // Round robin: both held valid from reset must alternate 0,1,0,1.
    @(posedge clk);
    #1;
    rst = 1'b0;
    g0 = n_grant;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g0, "rr", who);
      chk($sformatf("rr_grant%0d", k), 16'(who), 16'(k % 2));
      g0 = n_grant;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("rr");

    // Table vectors: single requester, checks grant, 2-cycle latency and result.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      set_port(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].err);
      req_valid = NREQ'(1) << tbl[i].port;
      g0 = n_grant;
      wait_grant(g0, $sformatf("tbl%0d", i), who);
      chk($sformatf("tbl%0d_grant", i), 16'(who), 16'(tbl[i].port));
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("tbl%0d_lat1_valid", i), 16'(rsp_valid), 16'h0000);
      chk($sformatf("tbl%0d_lat1_busy", i), 16'(busy), 16'h0001);
      @(negedge clk);
      chk($sformatf("tbl%0d_lat2_valid", i), 16'(rsp_valid), 16'h0001);
    end
    drain("tbl");

    // Backpressure: SUB held for 5 cycles while another requester waits.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_port(0, FP_ALU_SUB, 16'h4000, 16'h3F80, 16'h3F80, 1'b0);
    req_valid = 2'b01;
    g0 = n_grant;
    wait_grant(g0, "bp", who);
    chk("bp_grant", 16'(who), 16'h0000);
    @(posedge clk);
    #1;
    set_port(1, FP_ALU_ADD, 16'h4040, 16'h3F80, 16'h4080, 1'b0);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 16'(rsp_valid), 16'h0001);
      chk($sformatf("bp%0d_result", i), rsp_result, 16'h3F80);
      chk($sformatf("bp%0d_ready", i), 16'(req_ready), 16'h0000);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    hs0 = n_hs;
    g0 = n_grant;
    @(negedge clk);
    #1;
    chk("bp_handshake", 16'(n_hs - hs0), 16'h0001);
    chk("bp_next_grants", 16'(n_grant - g0), 16'h0001);
    chk("bp_next_port", 16'(last_grant), 16'h0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("bp_single_hs_valid", 16'(rsp_valid), 16'h0000);
    chk("bp_single_hs_count", 16'(n_hs - hs0), 16'h0001);
    drain("bp");

    // Reset while EXEC: in-flight op vanishes, pointer returns to port 0.
    @(posedge clk);
    #1;
    set_port(0, FP_ALU_SUB, 16'h4040, 16'h3F80, 16'h4000, 1'b0);
    req_valid = 2'b01;
    g0 = n_grant;
    wait_grant(g0, "mf", who);
    chk("mf_grant", 16'(who), 16'h0000);
    @(posedge clk);
    #1;
    chk("mf_in_exec", 16'(busy), 16'h0001);
    req_valid = '0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_port(0, FP_ALU_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    set_port(1, FP_ALU_ADD, 16'h4040, 16'h3F80, 16'h4080, 1'b0);
    g0 = n_grant;
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    chk("mf_rsp_valid", 16'(rsp_valid), 16'h0000);
    chk("mf_busy", 16'(busy), 16'h0000);
    chk("mf_regrant_count", 16'(n_grant - g0), 16'h0001);
    chk("mf_regrant_port", 16'(last_grant), 16'h0000);
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    g0 = n_grant;
    wait_grant(g0, "mf2", who);
    chk("mf2_grant", 16'(who), 16'h0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("mf");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_sb_empty", 16'(sb.size()), 16'h0000);
    chk("end_idle", 16'(busy), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
